// File: rtl/ex_div_pkg.sv
// Shared encodings for the EX-stage divider: FSM states and the
// handshake/stall levels exchanged with EX and the pipeline controller.
package ex_div_pkg;

    // Divider FSM states
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Result handshake levels
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    // Request levels on start_i
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    // Stall request levels towards the pipeline controller
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Active reset level
    localparam logic RST_ENABLE = 1'b1;

endpackage

// File: rtl/ex_div_step.sv
// One restoring radix-2 iteration: shift {partial remainder, dividend}
// left by one, subtract the divisor when it fits, and shift the resulting
// quotient bit into the LSB of the dividend register. After WIDTH steps the
// dividend register holds the quotient and the partial remainder holds the
// remainder.
module ex_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] part_rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] part_rem_next,
    output logic [WIDTH-1:0] dividend_next
);

    // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
    logic [WIDTH:0] shifted;
    logic           fits;

    // Compare/subtract/shift for a single quotient bit
    always_comb begin
        shifted = {part_rem, dividend[WIDTH-1]};
        fits    = (shifted >= {1'b0, divisor});
        if (fits) begin
            part_rem_next = shifted[WIDTH-1:0] - divisor;
        end else begin
            part_rem_next = shifted[WIDTH-1:0];
        end
        dividend_next = {dividend[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/ex_div.sv
// Multi-cycle DIV/DIVU/REM/REMU unit for the EX stage. Works on operand
// magnitudes one bit per cycle and fixes up the signs on the final
// iteration; quotient and remainder are presented together with ready_o.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             annul_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             ready_o,
    output logic             stallreq_o
);

    div_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] prem_reg, dvd_reg, dvs_reg;
    logic [WIDTH-1:0] prem_next, dvd_next;
    logic             neg_q_reg, neg_r_reg;
    logic [WIDTH-1:0] quot_reg, rem_reg;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             last_iter;
    logic             div_zero;

    // Operand magnitudes; only signed ops take absolute values
    assign a_neg     = signed_i & opdata1_i[WIDTH-1];
    assign b_neg     = signed_i & opdata2_i[WIDTH-1];
    assign abs_a     = a_neg ? -opdata1_i : opdata1_i;
    assign abs_b     = b_neg ? -opdata2_i : opdata2_i;
    assign div_zero  = (opdata2_i == '0);
    assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

    ex_div_step #(.WIDTH(WIDTH)) u_step (
        .part_rem      (prem_reg),
        .dividend      (dvd_reg),
        .divisor       (dvs_reg),
        .part_rem_next (prem_next),
        .dividend_next (dvd_next)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_reg <= DIV_FREE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; annul wins over everything, including a new start
    always_comb begin
        state_next = state_reg;
        if (annul_i) begin
            state_next = DIV_FREE;
        end else begin
            unique case (state_reg)
                DIV_FREE: begin
                    if (start_i == DIV_START) begin
                        state_next = div_zero ? DIV_BY_ZERO : DIV_ON;
                    end
                end
                DIV_BY_ZERO: state_next = DIV_END;
                DIV_ON:      state_next = last_iter ? DIV_END : DIV_ON;
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        state_next = DIV_FREE;
                    end
                end
                default:     state_next = DIV_FREE;
            endcase
        end
    end

    // Handshake outputs: ready while holding a result, stall while waiting
    always_comb begin
        ready_o    = (state_reg == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
        stallreq_o = ((start_i == DIV_START) && (state_reg != DIV_END) && !annul_i)
                     ? STOP : NO_STOP;
    end

    // Datapath: latch operands at start, iterate, register the final result.
    // An annulled cycle changes nothing so the visible outputs keep their value.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            cnt_reg   <= '0;
            prem_reg  <= '0;
            dvd_reg   <= '0;
            dvs_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            quot_reg  <= '0;
            rem_reg   <= '0;
        end else if (!annul_i) begin
            unique case (state_reg)
                DIV_FREE: begin
                    if (start_i == DIV_START && !div_zero) begin
                        dvd_reg   <= abs_a;
                        dvs_reg   <= abs_b;
                        neg_q_reg <= a_neg ^ b_neg;
                        neg_r_reg <= a_neg;
                        prem_reg  <= '0;
                        cnt_reg   <= '0;
                    end
                end
                DIV_BY_ZERO: begin
                    quot_reg <= '1;
                    rem_reg  <= opdata1_i;
                end
                DIV_ON: begin
                    prem_reg <= prem_next;
                    dvd_reg  <= dvd_next;
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    if (last_iter) begin
                        quot_reg <= neg_q_reg ? -dvd_next : dvd_next;
                        rem_reg  <= neg_r_reg ? -prem_next : prem_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quot_o = quot_reg;
    assign rem_o  = rem_reg;

endmodule
